// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory stage (master) and the data-memory responder (slave).
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid, once raised, holds its payload until that edge.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time into a word-organised RAM,
// answered after WAIT_STATES extra cycles with extended load data or an error flag.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [1:0]        dbg_state
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             a_we, a_uns, a_err, do_access, mem_we;
  logic [1:0]       a_size;
  logic [31:0]      a_addr, a_wdata, rd_word, load_data, wd;
  logic [IDX_W-1:0] a_idx;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [3:0]       be;

  // With zero wait states the access happens in IDLE, straight off the bus.
  always_comb begin
    a_we    = (state_q == S_IDLE) ? bus.req_we       : we_q;
    a_size  = (state_q == S_IDLE) ? bus.req_size     : size_q;
    a_uns   = (state_q == S_IDLE) ? bus.req_unsigned : uns_q;
    a_addr  = (state_q == S_IDLE) ? bus.req_addr     : addr_q;
    a_wdata = (state_q == S_IDLE) ? bus.req_wdata    : wdata_q;
    a_idx   = a_addr[IDX_W+1:2];
    a_err   = (a_size == 2'b11) ||
              (a_size == 2'b01 && a_addr[0]) ||
              (a_size == 2'b10 && a_addr[1:0] != 2'b00) ||
              (a_addr[31:2] >= 30'(DEPTH_WORDS));
    rd_word = mem[a_idx];
    rd_byte = rd_word[8*a_addr[1:0] +: 8];
    rd_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (a_size)
      2'b00:   load_data = {{24{~a_uns & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{~a_uns & rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
    case (a_size)
      2'b00: begin
        be = 4'b0001 << a_addr[1:0];
        wd = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be = a_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{a_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = a_wdata;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            do_access = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) do_access = 1'b1;
        else               cnt_d     = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_access) begin
      state_d = S_RESP;
      err_d   = a_err;
      rdata_d = (a_err || a_we) ? 32'd0 : load_data;
    end
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    // A store still in flight when reset arrives must never land.
    mem_we = do_access && a_we && !a_err && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[a_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign dbg_state      = state_q;
endmodule
